// File: rtl/debounce_pkg.sv
// Shared types and defaults for the debounce_sync input-conditioning stage.
// Types only: no latency, no backpressure.
package debounce_pkg;

  typedef enum logic [1:0] {
    STABLE_LO,
    QUAL_HI,
    STABLE_HI,
    QUAL_LO
  } db_state_t;

  localparam int DEFAULT_STABLE_CYCLES = 4;

endpackage

// File: rtl/sync_chain.sv
// sync_chain: STAGES-flop synchronizer for one asynchronous bit; latency STAGES edges.
// No backpressure: samples every clock, resets asynchronously to RESET_LEVEL.
module sync_chain #(
  parameter int   STAGES      = 2,
  parameter logic RESET_LEVEL = 1'b0
) (
  input  logic clk,
  input  logic reset_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] ff;

  // d feeds the first flop directly so nothing can glitch ahead of the metastability window
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ff <= {STAGES{RESET_LEVEL}};
    end else begin
      ff <= {ff[STAGES-2:0], d};
    end
  end

  assign q = ff[STAGES-1];

endmodule

// File: rtl/debounce_sync.sv
// debounce_sync: synchronize raw_in, then flip level after STABLE_CYCLES consecutive differing samples.
// Latency SYNC_STAGES+STABLE_CYCLES edges; no backpressure, rise/fall are one-cycle registered strobes.
module debounce_sync
  import debounce_pkg::*;
#(
  parameter int   SYNC_STAGES   = 2,
  parameter int   STABLE_CYCLES = DEFAULT_STABLE_CYCLES,
  parameter logic RESET_LEVEL   = 1'b0
) (
  input  logic clk,
  input  logic reset_n,
  input  logic raw_in,
  output logic level,
  output logic rise,
  output logic fall,
  output logic busy
);

  localparam int             CW          = $clog2(STABLE_CYCLES + 1);
  localparam logic [CW-1:0]  LAST        = CW'(STABLE_CYCLES - 1);
  localparam logic [CW-1:0]  ONE         = CW'(1);
  localparam bit             SINGLE      = (STABLE_CYCLES == 1);
  localparam db_state_t      RESET_STATE = RESET_LEVEL ? STABLE_HI : STABLE_LO;

  if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_stages
    $error("debounce_sync: SYNC_STAGES must be 2..4");
  end
  if (STABLE_CYCLES < 1) begin : g_bad_cycles
    $error("debounce_sync: STABLE_CYCLES must be >= 1");
  end

  logic          s;
  db_state_t     state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          level_nxt, rise_nxt, fall_nxt;

  sync_chain #(
    .STAGES      (SYNC_STAGES),
    .RESET_LEVEL (RESET_LEVEL)
  ) u_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .d       (raw_in),
    .q       (s)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= RESET_STATE;
      cnt   <= '0;
      level <= RESET_LEVEL;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      level <= level_nxt;
      rise  <= rise_nxt;
      fall  <= fall_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    level_nxt = level;
    rise_nxt  = 1'b0;
    fall_nxt  = 1'b0;
    case (state)
      STABLE_LO: begin
        if (s) begin
          if (SINGLE) begin
            level_nxt = 1'b1;
            rise_nxt  = 1'b1;
            state_nxt = STABLE_HI;
          end else begin
            cnt_nxt   = ONE;
            state_nxt = QUAL_HI;
          end
        end
      end
      QUAL_HI: begin
        if (!s) begin
          cnt_nxt   = '0;
          state_nxt = STABLE_LO;
        end else if (cnt == LAST) begin
          level_nxt = 1'b1;
          rise_nxt  = 1'b1;
          cnt_nxt   = '0;
          state_nxt = STABLE_HI;
        end else begin
          cnt_nxt = cnt + ONE;
        end
      end
      STABLE_HI: begin
        if (!s) begin
          if (SINGLE) begin
            level_nxt = 1'b0;
            fall_nxt  = 1'b1;
            state_nxt = STABLE_LO;
          end else begin
            cnt_nxt   = ONE;
            state_nxt = QUAL_LO;
          end
        end
      end
      QUAL_LO: begin
        if (s) begin
          cnt_nxt   = '0;
          state_nxt = STABLE_HI;
        end else if (cnt == LAST) begin
          level_nxt = 1'b0;
          fall_nxt  = 1'b1;
          cnt_nxt   = '0;
          state_nxt = STABLE_LO;
        end else begin
          cnt_nxt = cnt + ONE;
        end
      end
      default: begin
        state_nxt = RESET_STATE;
        cnt_nxt   = '0;
      end
    endcase
  end

  assign busy = (state == QUAL_HI) || (state == QUAL_LO);

  a_strobe_excl: assert property (@(posedge clk) disable iff (!reset_n) !(rise && fall));

endmodule

// File: tb/tb_debounce_sync.sv
// Scoreboarded bench: three debounce_sync configurations share raw_in/reset_n and are
// checked every cycle against a sample-window reference model.
`timescale 1ns/100ps
module tb_debounce_sync;

  localparam int N = 3;
  localparam int SS  [N] = '{2, 2, 3};
  localparam int SC  [N] = '{4, 1, 8};
  localparam int LAT [N] = '{6, 3, 11};
  localparam bit RL = 1'b0;

  typedef struct packed {
    logic [N-1:0] lv;
    logic [N-1:0] ri;
    logic [N-1:0] fa;
    logic [N-1:0] bz;
  } exp_t;

  typedef struct packed {
    int   inst;
    int   edge_no;
    logic is_rise;
  } strobe_t;

  logic clk = 1'b0;
  logic reset_n;
  logic raw_in;
  logic [N-1:0] lv, ri, fa, bz;

  int checks = 0;
  int failures = 0;
  int edge_n = 0;
  int nraw = 0;
  bit rawh [0:4095];
  bit mlv [N];
  int first_rise [N];
  exp_t    exp_q[$];
  strobe_t strobe_q[$];

  always #2 clk = ~clk;

  debounce_sync #(.SYNC_STAGES(2), .STABLE_CYCLES(4), .RESET_LEVEL(1'b0)) u_d0 (
    .clk(clk), .reset_n(reset_n), .raw_in(raw_in),
    .level(lv[0]), .rise(ri[0]), .fall(fa[0]), .busy(bz[0]));
  debounce_sync #(.SYNC_STAGES(2), .STABLE_CYCLES(1), .RESET_LEVEL(1'b0)) u_d1 (
    .clk(clk), .reset_n(reset_n), .raw_in(raw_in),
    .level(lv[1]), .rise(ri[1]), .fall(fa[1]), .busy(bz[1]));
  debounce_sync #(.SYNC_STAGES(3), .STABLE_CYCLES(8), .RESET_LEVEL(1'b0)) u_d2 (
    .clk(clk), .reset_n(reset_n), .raw_in(raw_in),
    .level(lv[2]), .rise(ri[2]), .fall(fa[2]), .busy(bz[2]));

  task automatic chk(input bit ok, input string nm, input int inst, input int act, input int req);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s inst=%0d got=%0d want=%0d t=%0t", nm, inst, act, req, $time);
    end
  endtask

  // Synchronized sample seen by the filter at edge e: raw from SYNC_STAGES edges earlier.
  function automatic bit sval(input int i, input int e);
    if (e - SS[i] >= 1) return rawh[e - SS[i]];
    return RL;
  endfunction

  task automatic model_reset();
    nraw = 0;
    edge_n = 0;
    for (int i = 0; i < N; i++) mlv[i] = RL;
  endtask

  // Level flips when the last STABLE_CYCLES samples since reset all differ from it.
  task automatic model_edge();
    exp_t    rec;
    strobe_t st;
    bit      flip;
    nraw++;
    rawh[nraw] = raw_in;
    edge_n = nraw;
    rec = '0;
    for (int i = 0; i < N; i++) begin
      flip = 1'b1;
      for (int k = 0; k < SC[i]; k++) begin
        if (nraw - k < 1 || sval(i, nraw - k) == mlv[i]) flip = 1'b0;
      end
      if (flip) begin
        mlv[i] = ~mlv[i];
        st.inst = i;
        st.edge_no = nraw;
        st.is_rise = mlv[i];
        strobe_q.push_back(st);
      end
      rec.lv[i] = mlv[i];
      rec.ri[i] = flip && mlv[i];
      rec.fa[i] = flip && !mlv[i];
      rec.bz[i] = (sval(i, nraw) != mlv[i]);
    end
    exp_q.push_back(rec);
  endtask

  task automatic step(input bit r);
    raw_in = r;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    #0.5;
  endtask

  task automatic hold(input bit r, input int n);
    repeat (n) step(r);
  endtask

  task automatic check_all_zero(input string nm);
    for (int i = 0; i < N; i++) begin
      chk(lv[i] === 1'b0 && ri[i] === 1'b0 && fa[i] === 1'b0 && bz[i] === 1'b0,
          nm, i, {28'd0, lv[i], ri[i], fa[i], bz[i]}, 0);
    end
  endtask

  task automatic check_latency(input string nm);
    for (int i = 0; i < N; i++) chk(first_rise[i] == LAT[i], nm, i, first_rise[i], LAT[i]);
  endtask

  // Monitor: pops one expectation per active cycle, and one strobe record per observed strobe.
  always @(negedge clk) begin
    exp_t    e;
    strobe_t st;
    if (!reset_n) begin
      for (int i = 0; i < N; i++) first_rise[i] = -1;
    end else if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      for (int i = 0; i < N; i++) begin
        chk(lv[i] === e.lv[i], "level", i, int'(lv[i]), int'(e.lv[i]));
        chk(ri[i] === e.ri[i], "rise",  i, int'(ri[i]), int'(e.ri[i]));
        chk(fa[i] === e.fa[i], "fall",  i, int'(fa[i]), int'(e.fa[i]));
        chk(bz[i] === e.bz[i], "busy",  i, int'(bz[i]), int'(e.bz[i]));
        if (ri[i] === 1'b1 || fa[i] === 1'b1) begin
          if (strobe_q.size() == 0) begin
            chk(1'b0, "extra_strobe", i, edge_n, -1);
          end else begin
            st = strobe_q.pop_front();
            chk(st.inst == i && st.edge_no == edge_n && st.is_rise == ri[i],
                "strobe_event", i, edge_n, st.edge_no);
          end
          if (ri[i] === 1'b1 && first_rise[i] < 0) first_rise[i] = edge_n;
        end
      end
    end
  end

  initial begin
    #200000;
    failures++;
    $display("FAIL watchdog t=%0t", $time);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

  initial begin
    bit r;
    int n;
    reset_n = 1'b0;
    raw_in  = 1'b1;
    model_reset();
    repeat (3) begin
      @(negedge clk);
      #0.5;
      check_all_zero("reset_hold");
    end
    reset_n = 1'b1;

    // Release with raw_in already high, then a clean held step.
    hold(1'b1, 20);
    check_latency("latency_after_release");

    hold(1'b0, 20);
    hold(1'b1, 20);

    hold(1'b0, 20);
    step(1'b1); step(1'b0); step(1'b1); step(1'b0);
    hold(1'b0, 12);

    hold(1'b1, 15);
    hold(1'b0, 3);
    step(1'b1);
    hold(1'b0, 15);

    // Reset in the middle of a rising qualification.
    hold(1'b1, 4);
    chk(bz[0] === 1'b1, "busy_pre_reset", 0, int'(bz[0]), 1);
    #0.5;
    reset_n = 1'b0;
    model_reset();
    #0.5;
    check_all_zero("async_reset");
    repeat (2) @(negedge clk);
    #0.5;
    check_all_zero("reset_mid_qual_hold");
    reset_n = 1'b1;
    hold(1'b1, 15);
    check_latency("latency_after_midqual_reset");

    repeat (40) begin
      r = 1'($urandom_range(0, 1));
      n = $urandom_range(1, 12);
      hold(r, n);
    end

    repeat (2) @(negedge clk);
    chk(exp_q.size() == 0, "exp_q_drained", 0, exp_q.size(), 0);
    chk(strobe_q.size() == 0, "strobe_q_drained", 0, strobe_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
